alu_arbiter: RTL and testbench
==============================

// Module: alu_arbiter
// PURPOSE
//   Shares one combinational ALU between two requesters (port 0, port 1).
//   Round-robin arbitration with valid/ready on both request and response sides.
//   Sits between the issue logic / address-generation unit and the ALU.
//   Captures operands, drives the ALU for one cycle, then registers and holds the result until accepted.
// PARAMETERS
//   WIDTH   32  operand/result width; must match the ALU data width
//   CTRL_W  4   ALU control code width
// PORTS
//   clk          in   1       single clock; all state on rising edge
//   rst_n        in   1       reset: asynchronous assert, active-low
//   reqN_valid   in   1       request valid, N=0,1; held with payload until accepted
//   reqN_ready   out  1       request accepted this cycle, N=0,1
//   reqN_scra    in   WIDTH   operand A
//   reqN_scrb    in   WIDTH   operand B
//   reqN_ctrl    in   CTRL_W  ALU control code; passed through unchanged
//   rspN_valid   out  1       response valid, N=0,1
//   rspN_ready   in   1       consumer accepts response
//   rspN_result  out  WIDTH   registered ALU result
//   rspN_zero    out  1       registered ALU zero flag
//   alu_scra     out  WIDTH   to ALU operand A
//   alu_scrb     out  WIDTH   to ALU operand B
//   alu_control  out  CTRL_W  to ALU control
//   alu_result   in   WIDTH   from ALU result
//   alu_zero     in   1       from ALU zero flag
//   busy         out  1       state != IDLE
// BEHAVIOUR
//   States:
//     IDLE -> EXEC on accept
//     EXEC -> RESP unconditionally
//     RESP -> IDLE on rsp handshake of the owning port
//   IDLE:
//     - Grant picks among the valid requesters.
//     - Only one valid: that requester is granted.
//     - Both valid: the requester that was not granted last (pointer `last`) wins.
//     - reqN_ready = (state==IDLE) & grantN. Combinational from reqN_valid; at most one ready high per cycle.
//     - On accept: latch scra, scrb, ctrl into operand registers; latch owner id; set last = owner.
//   EXEC:
//     - ALU is driven from the operand registers; its output settles within the cycle.
//     - Capture alu_result and alu_zero into result registers at the end of the cycle.
//   RESP:
//     - rsp<owner>_valid = 1; the other port's rsp valid stays 0.
//     - result/zero held stable until rsp<owner>_ready.
//     - Both reqN_ready are 0 in RESP and EXEC; no new accept occurs on the handshake cycle.
//   Latency:
//     - accept at cycle T -> rsp valid at T+2.
//     - Minimum spacing is 3 cycles per operation.
//   ALU port values:
//     - alu_* outputs always reflect the operand registers, including outside EXEC.
//     - Reset value of the operand registers is 0.
//   Data handling:
//     - No arithmetic inside this block; the ALU result is passed through bit-exact.
//     - This includes divide-by-zero (all ones) and unsupported codes (0, zero=1).
//   Reset (async, any state):
//     - state=IDLE, last=1 (so port 0 wins the first tie).
//     - All outputs 0: ready, rsp valid, result, zero, busy, alu_*.
//     - Any in-flight operation is dropped; no response is issued after release.
//   Robustness:
//     - A requester dropping valid before accept is legal; no grant or state change results.
//     - rspN_ready asserted while rspN_valid=0 is ignored.
// STRUCTURE
//   Package alu_pkg:
//     - ALU control localparams: AND 0000, OR 0001, ADD 0010, SUB 0110, SLT 0111, DIV 1010.
//     - State encoding: IDLE, EXEC, RESP.
//   Sub-module rr_arb2:
//     - 2-way round-robin grant; inputs valid[1:0] and last; output one-hot grant.
//   Top level: FSM, operand/result registers, response muxing.
// TESTING
//   - req0 ADD 5,7 alone -> req0_ready at T; rsp0_valid at T+2; result=12, zero=0; rsp1_valid stays 0.
//   - Both valid continuously after reset: grants 0,1,0,1. req1 SUB 3,3 -> rsp1_result=0, rsp1_zero=1.
//   - rsp0_ready low 5 cycles with req1 pending -> rsp0 valid/result stable; req1_ready=0 throughout.
//     Then: req1 accepted one cycle after the handshake.
//   - req1 DIV 100,7 -> 14. req1 DIV 9,0 -> 0xFFFFFFFF, zero=0.
//   - req0 SLT 2,9 -> 1. req0 ctrl 4'b1111 -> result 0, zero=1.
//   - rst_n low during EXEC -> all outputs 0 immediately; no rsp after release.
//     Then: next tie grants port 0.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU arbiter: ALU control codes and arbiter FSM states.
package alu_pkg;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_DIV = 4'b1010;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant: a lone requester always wins, a tie goes to the
// requester that was not granted last.
module rr_arb2 (
  input  logic [1:0] valid,
  input  logic       last,
  output logic [1:0] grant
);

  always_comb begin
    grant = '0;
    if (valid == 2'b11) begin
      grant = last ? 2'b01 : 2'b10;
    end else begin
      grant = valid;
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU between two requesters: accept, drive the ALU
// for one cycle from operand registers, then hold the registered result.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int CTRL_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [WIDTH-1:0]  req0_scra,
  input  logic [WIDTH-1:0]  req0_scrb,
  input  logic [CTRL_W-1:0] req0_ctrl,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [WIDTH-1:0]  req1_scra,
  input  logic [WIDTH-1:0]  req1_scrb,
  input  logic [CTRL_W-1:0] req1_ctrl,
  output logic              rsp0_valid,
  input  logic              rsp0_ready,
  output logic [WIDTH-1:0]  rsp0_result,
  output logic              rsp0_zero,
  output logic              rsp1_valid,
  input  logic              rsp1_ready,
  output logic [WIDTH-1:0]  rsp1_result,
  output logic              rsp1_zero,
  output logic [WIDTH-1:0]  alu_scra,
  output logic [WIDTH-1:0]  alu_scrb,
  output logic [CTRL_W-1:0] alu_control,
  input  logic [WIDTH-1:0]  alu_result,
  input  logic              alu_zero,
  output logic              busy
);

  state_t             state, state_nxt;
  logic               last, owner;
  logic [1:0]         grant;
  logic               accept;
  logic [WIDTH-1:0]   op_a, op_b, res;
  logic [CTRL_W-1:0]  op_c;
  logic               res_zero;

  rr_arb2 u_arb (
    .valid ({req1_valid, req0_valid}),
    .last  (last),
    .grant (grant)
  );

  assign accept = req0_ready | req1_ready;

  // Ready is also gated by rst_n so every output reads 0 while reset is held.
  always_comb begin
    state_nxt  = state;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    rsp0_valid = 1'b0;
    rsp1_valid = 1'b0;
    busy       = 1'b0;
    case (state)
      IDLE: begin
        req0_ready = rst_n & grant[0];
        req1_ready = rst_n & grant[1];
        if (|grant) state_nxt = EXEC;
      end
      EXEC: begin
        busy      = 1'b1;
        state_nxt = RESP;
      end
      RESP: begin
        busy       = 1'b1;
        rsp0_valid = ~owner;
        rsp1_valid = owner;
        if (owner ? rsp1_ready : rsp0_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      last     <= 1'b1;
      owner    <= 1'b0;
      op_a     <= '0;
      op_b     <= '0;
      op_c     <= '0;
      res      <= '0;
      res_zero <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        owner <= grant[1];
        last  <= grant[1];
        op_a  <= grant[1] ? req1_scra : req0_scra;
        op_b  <= grant[1] ? req1_scrb : req0_scrb;
        op_c  <= grant[1] ? req1_ctrl : req0_ctrl;
      end
      if (state == EXEC) begin
        res      <= alu_result;
        res_zero <= alu_zero;
      end
    end
  end

  assign alu_scra    = op_a;
  assign alu_scrb    = op_b;
  assign alu_control = op_c;
  assign rsp0_result = res;
  assign rsp0_zero   = res_zero;
  assign rsp1_result = res;
  assign rsp1_zero   = res_zero;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: behavioural ALU stub, transaction-level reference
// model checked every cycle, and directed scenarios with literal expectations.
module tb_alu_arbiter;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic        req0_ready, req1_ready;
  logic [31:0] req0_scra = '0, req0_scrb = '0, req1_scra = '0, req1_scrb = '0;
  logic [3:0]  req0_ctrl = '0, req1_ctrl = '0;
  logic        rsp0_valid, rsp1_valid;
  logic        rsp0_ready = 1'b1, rsp1_ready = 1'b1;
  logic [31:0] rsp0_result, rsp1_result;
  logic        rsp0_zero, rsp1_zero;
  logic [31:0] alu_scra, alu_scrb, alu_result;
  logic [3:0]  alu_control;
  logic        alu_zero;
  logic        busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.WIDTH(32), .CTRL_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_scra(req0_scra), .req0_scrb(req0_scrb), .req0_ctrl(req0_ctrl),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_scra(req1_scra), .req1_scrb(req1_scrb), .req1_ctrl(req1_ctrl),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
    .rsp0_result(rsp0_result), .rsp0_zero(rsp0_zero),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp1_result(rsp1_result), .rsp1_zero(rsp1_zero),
    .alu_scra(alu_scra), .alu_scrb(alu_scrb), .alu_control(alu_control),
    .alu_result(alu_result), .alu_zero(alu_zero),
    .busy(busy)
  );

  function automatic logic [31:0] alu_f(input logic [31:0] a, input logic [31:0] b,
                                        input logic [3:0] c);
    case (c)
      ALU_AND: return a & b;
      ALU_OR:  return a | b;
      ALU_ADD: return a + b;
      ALU_SUB: return a - b;
      ALU_SLT: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      ALU_DIV: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      default: return 32'd0;
    endcase
  endfunction

  assign alu_result = alu_f(alu_scra, alu_scrb, alu_control);
  assign alu_zero   = (alu_result == 32'd0);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: one operation outstanding at a time, response
  // visible two cycles after its accept, tie broken against the last winner.
  bit          m_pend, m_own, m_last = 1'b1;
  int          m_cyc = 0, m_acc = 0, g;
  logic [1:0]  e_rv;
  logic [31:0] m_a = '0, m_b = '0, m_res = '0;
  logic [3:0]  m_c = '0;
  logic        m_zero = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      m_pend = 1'b0; m_last = 1'b1; m_a = '0; m_b = '0; m_c = '0;
      m_res = '0; m_zero = 1'b0;
      chk("rst_outputs", {busy, req0_ready, req1_ready, rsp0_valid, rsp1_valid,
                          rsp0_zero, rsp1_zero}, 32'd0);
      chk("rst_result", rsp0_result | rsp1_result, 32'd0);
      chk("rst_alu", alu_scra | alu_scrb | {28'd0, alu_control}, 32'd0);
    end else begin
      e_rv = 2'b00;
      g = -1;
      if (m_pend) begin
        if (m_cyc - m_acc >= 2) e_rv[m_own] = 1'b1;
      end else if (req0_valid && req1_valid) g = m_last ? 0 : 1;
      else if (req0_valid) g = 0;
      else if (req1_valid) g = 1;
      chk("m_ready0", req0_ready, (g == 0));
      chk("m_ready1", req1_ready, (g == 1));
      chk("m_busy", busy, m_pend);
      chk("m_rsp_valid", {rsp1_valid, rsp0_valid}, e_rv);
      chk("m_alu_a", alu_scra, m_a);
      chk("m_alu_b", alu_scrb, m_b);
      chk("m_alu_ctrl", alu_control, m_c);
      if (e_rv[0]) chk("m_rsp0", {rsp0_zero, rsp0_result}, {m_zero, m_res});
      if (e_rv[1]) chk("m_rsp1", {rsp1_zero, rsp1_result}, {m_zero, m_res});
      if (g >= 0) begin
        m_pend = 1'b1; m_own = g[0]; m_last = g[0]; m_acc = m_cyc;
        m_a = g[0] ? req1_scra : req0_scra;
        m_b = g[0] ? req1_scrb : req0_scrb;
        m_c = g[0] ? req1_ctrl : req0_ctrl;
        m_res = alu_f(m_a, m_b, m_c);
        m_zero = (m_res == 32'd0);
      end else if (e_rv != 2'b00 && (m_own ? rsp1_ready : rsp0_ready)) begin
        m_pend = 1'b0;
      end
    end
    m_cyc++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int p, input logic v, input logic [31:0] a,
                         input logic [31:0] b, input logic [3:0] c);
    if (p == 0) begin
      req0_valid = v; req0_scra = a; req0_scrb = b; req0_ctrl = c;
    end else begin
      req1_valid = v; req1_scra = a; req1_scrb = b; req1_ctrl = c;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  // Called one tick after a rising edge with requests set; returns with the
  // response of the expected port visible.
  task automatic run_op(input int p, input logic drop, input logic [31:0] er, input logic ez);
    logic got = 1'b0;
    for (int n = 0; n < 10; n++) begin
      #1;
      got = req0_ready | req1_ready;
      if (got) break;
      step();
    end
    if (!got) begin
      chk("accept_timeout", 32'd0, 32'd1);
    end else begin
      chk("grant_port", {31'd0, req1_ready}, p);
      step();
      if (drop) begin
        if (p == 0) req0_valid = 1'b0; else req1_valid = 1'b0;
      end
      #1;
      chk("exec_no_rsp", {rsp1_valid, rsp0_valid}, 32'd0);
      step();
      #1;
      chk("rsp_valid_t2", {rsp1_valid, rsp0_valid}, (p == 0) ? 32'd1 : 32'd2);
      chk("rsp_result", (p == 0) ? rsp0_result : rsp1_result, er);
      chk("rsp_zero", (p == 0) ? rsp0_zero : rsp1_zero, ez);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();
    step();

    // Lone ADD on port 0.
    set_req(0, 1'b1, 32'd5, 32'd7, ALU_ADD);
    run_op(0, 1'b1, 32'd12, 1'b0);
    step();

    // Both held after reset: alternating grants.
    do_reset();
    set_req(0, 1'b1, 32'd1, 32'd2, ALU_ADD);
    set_req(1, 1'b1, 32'd3, 32'd3, ALU_SUB);
    for (int k = 0; k < 4; k++) begin
      if (k % 2 == 0) run_op(0, 1'b0, 32'd3, 1'b0);
      else            run_op(1, 1'b0, 32'd0, 1'b1);
      step();
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    step();

    // Response back-pressure with port 1 waiting.
    do_reset();
    rsp0_ready = 1'b0;
    set_req(0, 1'b1, 32'd10, 32'd20, ALU_ADD);
    set_req(1, 1'b1, 32'd100, 32'd7, ALU_DIV);
    run_op(0, 1'b1, 32'd30, 1'b0);
    for (int k = 0; k < 5; k++) begin
      step();
      #1;
      chk("stall_rsp0_valid", rsp0_valid, 1'b1);
      chk("stall_rsp0_result", rsp0_result, 32'd30);
      chk("stall_req1_ready", req1_ready, 1'b0);
    end
    rsp0_ready = 1'b1;
    #1;
    chk("hs_no_accept", req1_ready, 1'b0);
    step();
    #1;
    chk("accept_after_hs", req1_ready, 1'b1);
    run_op(1, 1'b1, 32'd14, 1'b0);
    step();

    // Divide by zero, SLT, unsupported control code.
    set_req(1, 1'b1, 32'd9, 32'd0, ALU_DIV);
    run_op(1, 1'b1, 32'hFFFF_FFFF, 1'b0);
    step();
    set_req(0, 1'b1, 32'd2, 32'd9, ALU_SLT);
    run_op(0, 1'b1, 32'd1, 1'b0);
    step();
    set_req(0, 1'b1, 32'd5, 32'd5, 4'b1111);
    run_op(0, 1'b1, 32'd0, 1'b1);
    step();

    // Reset asserted mid-operation.
    set_req(0, 1'b1, 32'd1, 32'd1, ALU_ADD);
    #1;
    chk("pre_rst_accept", req0_ready, 1'b1);
    step();
    req0_valid = 1'b0;
    #1;
    chk("exec_busy", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("async_busy", busy, 1'b0);
    chk("async_alu_a", alu_scra, 32'd0);
    chk("async_alu_ctrl", alu_control, 32'd0);
    chk("async_result", rsp0_result, 32'd0);
    set_req(0, 1'b1, 32'd4, 32'd4, ALU_OR);
    set_req(1, 1'b1, 32'd6, 32'd3, ALU_AND);
    #1;
    chk("rst_ready", {req1_ready, req0_ready}, 32'd0);
    step();
    step();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      #1;
      chk("no_rsp_after_rst", {busy, rsp1_valid, rsp0_valid}, 32'd0);
    end
    set_req(0, 1'b1, 32'd4, 32'd4, ALU_OR);
    set_req(1, 1'b1, 32'd6, 32'd3, ALU_AND);
    run_op(0, 1'b1, 32'd4, 1'b0);
    req1_valid = 1'b0;
    step();
    step();
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
